// File: rtl/imem_pkg.sv
// Shared defaults, fetch-controller state encoding and response-entry layout for the
// instruction-memory fetch path.
package imem_pkg;

  localparam int unsigned AddrWidthDef = 11;
  localparam int unsigned DataWidthDef = 32;
  localparam int unsigned NumWmasksDef = 4;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StLoad
  } imem_state_e;

  typedef struct packed {
    logic [DataWidthDef-1:0] data;
    logic                    err;
  } rsp_entry_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response FIFO with simultaneous push/pop and a single-cycle flush.
// The head reads as zero while empty so the response outputs idle at zero.
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter type entry_t = rsp_entry_t
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     push_data,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count is non-zero.
  always_ff @(posedge clock) begin
    if (push && !reset && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller in front of a 1-cycle-latency dual-port SRAM.
// Define IMEM_LOAD_EN to build the program-load path (DRAIN/LOAD states, load_* ports).
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned NUM_WMASKS = NumWmasksDef
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  flush,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
`ifdef IMEM_LOAD_EN
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [31:0]           load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic [NUM_WMASKS-1:0] load_mask,
`endif
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
  } entry_t;

  imem_state_e state_q, state_d;
  logic        if_valid_q, if_err_q;
  logic [1:0]  fifo_count;
  logic        req_err, accept, push, pop;
  entry_t      push_entry, head;

  assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  // In-flight slot counts against FIFO space so a returning read always has room.
  assign req_ready = !reset && !flush && (state_q == StRun) &&
                     (({1'b0, fifo_count} + {2'b00, if_valid_q}) < 3'd2);
  assign accept    = req_valid && req_ready;

  assign sram_csb1  = !(accept && !req_err);
  assign sram_addr1 = sram_csb1 ? '0 : req_addr[ADDR_WIDTH+1:2];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StRun;
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= accept;
      if_err_q   <= accept && req_err;
    end
  end

  assign push            = if_valid_q && !flush;
  assign pop             = rsp_valid && rsp_ready && !flush;
  assign push_entry.data = if_err_q ? '0 : sram_dout1;
  assign push_entry.err  = if_err_q;

  imem_rsp_fifo #(
    .entry_t (entry_t)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_entry),
    .head      (head),
    .count     (fifo_count)
  );

  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_data  = head.data;
  assign rsp_err   = head.err;

`ifdef IMEM_LOAD_EN
  logic load_ok;
  assign load_ok = (load_addr[1:0] == 2'b00) && ((load_addr >> (ADDR_WIDTH + 2)) == 32'd0);

  always_comb begin
    state_d     = state_q;
    load_ready  = 1'b0;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (!reset) begin
      unique case (state_q)
        StRun:   if (load_valid) state_d = StDrain;
        StDrain: if (!if_valid_q) state_d = StLoad;
        StLoad: begin
          load_ready = 1'b1;
          if (!load_valid) begin
            state_d = StRun;
          end else if (load_ok) begin
            // Bad beats are still accepted, just never written.
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = load_mask;
            sram_addr0  = load_addr[ADDR_WIDTH+1:2];
            sram_din0   = load_data;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end
`else
  assign state_d     = StRun;
  assign sram_csb0   = 1'b1;
  assign sram_web0   = 1'b1;
  assign sram_wmask0 = '0;
  assign sram_addr0  = '0;
  assign sram_din0   = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a behavioural 1-cycle SRAM.
// Load-path vectors are built only when IMEM_LOAD_EN is defined.
module tb_imem_fetch_ctrl;
  import imem_pkg::*;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [31:0]   req_addr;
  logic          flush;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
`ifdef IMEM_LOAD_EN
  logic          load_valid, load_ready;
  logic [31:0]   load_addr;
  logic [DW-1:0] load_data;
  logic [NW-1:0] load_mask;
`endif
  logic          sram_csb0, sram_web0, sram_csb1;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0, sram_dout1;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [2**AW];

  always #5 clock = ~clock;

  imem_fetch_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WMASKS (NW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .flush       (flush),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
`ifdef IMEM_LOAD_EN
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_mask   (load_mask),
`endif
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (sram_dout1)
  );

  // Read data appears after the edge that samples csb1/addr1, stable for the next cycle.
  always @(posedge clock) begin
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
    if (!sram_csb0 && !sram_web0) begin
      for (int b = 0; b < NW; b++) begin
        if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'hA500_0000 | i;
    sram_dout1 = '0;
    reset      = 1'b1;
    req_valid  = 1'b1;
    req_addr   = 32'h10;
    flush      = 1'b0;
    rsp_ready  = 1'b1;
`ifdef IMEM_LOAD_EN
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    load_mask  = '0;
`endif

    // Reset, with a request held to show it is refused.
    next_cycle();
    next_cycle();
    mid();
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_csb0", sram_csb0, 1);
    check_eq("rst_web0", sram_web0, 1);
    check_eq("rst_wmask0", sram_wmask0, 0);
    check_eq("rst_addr0", sram_addr0, 0);
    check_eq("rst_din0", sram_din0, 0);
    check_eq("rst_csb1", sram_csb1, 1);
    check_eq("rst_addr1", sram_addr1, 0);
    next_cycle();
    reset     = 1'b0;
    req_valid = 1'b0;
    next_cycle();

    // Aligned fetch of 0x10: word 4 addressed in accept cycle, data after the in-flight cycle.
    req_valid = 1'b1;
    req_addr  = 32'h10;
    mid();
    check_eq("f10_req_ready", req_ready, 1);
    check_eq("f10_csb1", sram_csb1, 0);
    check_eq("f10_addr1", sram_addr1, 4);
    next_cycle();
    req_valid = 1'b0;
    mid();
    check_eq("f10_inflight_rsp_valid", rsp_valid, 0);
    next_cycle();
    mid();
    check_eq("f10_rsp_valid", rsp_valid, 1);
    check_eq("f10_rsp_data", rsp_data, 32'hA500_0004);
    check_eq("f10_rsp_err", rsp_err, 0);
    next_cycle();
    mid();
    check_eq("f10_popped", rsp_valid, 0);

    // Misaligned then out-of-range fetch: error responses, SRAM untouched.
    next_cycle();
    req_valid = 1'b1;
    req_addr  = 32'h2;
    mid();
    check_eq("e2_req_ready", req_ready, 1);
    check_eq("e2_csb1", sram_csb1, 1);
    next_cycle();
    req_addr = 32'h2000;
    mid();
    check_eq("e2000_req_ready", req_ready, 1);
    check_eq("e2000_csb1", sram_csb1, 1);
    next_cycle();
    req_valid = 1'b0;
    mid();
    check_eq("e2_rsp_valid", rsp_valid, 1);
    check_eq("e2_rsp_err", rsp_err, 1);
    check_eq("e2_rsp_data", rsp_data, 0);
    next_cycle();
    mid();
    check_eq("e2000_rsp_valid", rsp_valid, 1);
    check_eq("e2000_rsp_err", rsp_err, 1);
    check_eq("e2000_rsp_data", rsp_data, 0);
    next_cycle();
    mid();
    check_eq("err_drained", rsp_valid, 0);

    // Backpressure: three back-to-back fetches, only two fit.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h100;
    next_cycle();
    req_addr = 32'h104;
    mid();
    check_eq("bp2_req_ready", req_ready, 1);
    next_cycle();
    req_addr = 32'h108;
    mid();
    check_eq("bp3_req_ready", req_ready, 0);
    check_eq("bp3_csb1", sram_csb1, 1);
    next_cycle();
    mid();
    check_eq("bp_full_req_ready", req_ready, 0);
    check_eq("bp_full_rsp_valid", rsp_valid, 1);
    next_cycle();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    mid();
    check_eq("bp_rsp0_data", rsp_data, 32'hA500_0040);
    next_cycle();
    mid();
    check_eq("bp_rsp1_valid", rsp_valid, 1);
    check_eq("bp_rsp1_data", rsp_data, 32'hA500_0041);
    next_cycle();
    mid();
    check_eq("bp_drained", rsp_valid, 0);

    // Flush one cycle after accepting 0x20 with word 7 already queued.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h1C;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    req_valid = 1'b1;
    req_addr  = 32'h20;
    mid();
    check_eq("fl_queued_data", rsp_data, 32'hA500_0007);
    check_eq("fl_accept20", req_ready, 1);
    next_cycle();
    flush    = 1'b1;
    req_addr = 32'h24;
    mid();
    check_eq("fl_req_ready", req_ready, 0);
    check_eq("fl_csb1", sram_csb1, 1);
    next_cycle();
    flush     = 1'b0;
    req_valid = 1'b0;
    mid();
    check_eq("fl_rsp_valid", rsp_valid, 0);
    next_cycle();
    mid();
    check_eq("fl_no_rsp20", rsp_valid, 0);
    next_cycle();

`ifdef IMEM_LOAD_EN
    // Load beat arriving while a fetch of 0x8 is in flight.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h8;
    next_cycle();
    req_valid  = 1'b0;
    load_valid = 1'b1;
    load_addr  = 32'h8;
    load_data  = 32'hDEAD_BEEF;
    load_mask  = 4'b0011;
    mid();
    check_eq("ld_run_load_ready", load_ready, 0);
    check_eq("ld_run_csb0", sram_csb0, 1);
    next_cycle();
    mid();
    check_eq("ld_drain_state", dut.state_q, StDrain);
    check_eq("ld_drain_load_ready", load_ready, 0);
    check_eq("ld_old_rsp_data", rsp_data, 32'hA500_0002);
    next_cycle();
    mid();
    check_eq("ld_load_ready", load_ready, 1);
    check_eq("ld_csb0", sram_csb0, 0);
    check_eq("ld_web0", sram_web0, 0);
    check_eq("ld_addr0", sram_addr0, 2);
    check_eq("ld_din0", sram_din0, 32'hDEAD_BEEF);
    check_eq("ld_wmask0", sram_wmask0, 4'b0011);
    next_cycle();
    load_valid = 1'b0;
    mid();
    check_eq("ld_end_csb0", sram_csb0, 1);
    next_cycle();
    req_valid = 1'b1;
    req_addr  = 32'h8;
    next_cycle();
    req_valid = 1'b0;
    next_cycle();
    mid();
    check_eq("ld_merged_data", rsp_data, 32'hA500_BEEF);
    next_cycle();

    // Reset while in LOAD.
    load_valid = 1'b1;
    load_addr  = 32'hC;
    load_data  = 32'h1111_1111;
    load_mask  = 4'b1111;
    next_cycle();
    next_cycle();
    mid();
    check_eq("rl_in_load", load_ready, 1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset      = 1'b0;
    load_valid = 1'b0;
    mid();
    check_eq("rl_csb0", sram_csb0, 1);
    check_eq("rl_load_ready", load_ready, 0);
    check_eq("rl_state", dut.state_q, StRun);
    check_eq("rl_rsp_valid", rsp_valid, 0);
    next_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
